// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one result bit per cycle, with request/response handshakes and a tag echoed back.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_result_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               resp_valid_q, resp_valid_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               a_signed, b_signed;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      rem_sh;
    logic               div_ge;
    logic [XLEN-1:0]    div_diff;
    logic [PW-1:0]      prod_fix;
    logic [XLEN-1:0]    quo_fix, rem_fix;
    logic               req_div_zero, req_div_ovf;

    // Operand signedness by funct3; MUL treated as signed, its low half is sign-agnostic
    always_comb begin
        a_signed = (op_q != OP_MULHU) && (op_q != OP_DIVU) && (op_q != OP_REMU);
        b_signed = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        a_mag    = (a_signed && a_q[XLEN-1]) ? -a_q : a_q;
        b_mag    = (b_signed && b_q[XLEN-1]) ? -b_q : b_q;
    end

    // Datapath: one multiply or divide step, plus final sign correction
    always_comb begin
        mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
        rem_sh   = acc_q[PW-1:XLEN-1];
        div_ge   = rem_sh >= {1'b0, b_q};
        div_diff = rem_sh[XLEN-1:0] - b_q;
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_a_q ? -acc_q[PW-1:XLEN] : acc_q[PW-1:XLEN];
    end

    always_comb begin
        req_div_zero = req_op_i[2] && (req_b_i == '0);
        req_div_ovf  = req_op_i[2] && !req_op_i[0]
                    && (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (req_b_i == '1);
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        sign_a_d     = sign_a_q;
        sign_b_d     = sign_b_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        result_d     = result_q;
        resp_valid_d = resp_valid_q;

        if (flush_i) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && ready_q) begin
                        op_d  = req_op_i;
                        a_d   = req_a_i;
                        b_d   = req_b_i;
                        tag_d = req_tag_i;
                        if (req_div_zero) begin
                            result_d     = req_op_i[1] ? req_a_i : '1;
                            resp_valid_d = 1'b1;
                            state_d      = S_DONE;
                        end else if (req_div_ovf) begin
                            result_d     = req_op_i[1] ? '0 : req_a_i;
                            resp_valid_d = 1'b1;
                            state_d      = S_DONE;
                        end else begin
                            state_d = S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    sign_a_d = a_signed && a_q[XLEN-1];
                    sign_b_d = b_signed && b_q[XLEN-1];
                    a_d      = a_mag;
                    b_d      = b_mag;
                    acc_d    = op_q[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                    cnt_d    = CNT_W'(XLEN - 1);
                    state_d  = S_CALC;
                end
                S_CALC: begin
                    // Divide keeps {remainder, dividend/quotient}; multiply keeps {partial, multiplier}
                    if (op_q[2]) begin
                        acc_d = {(div_ge ? div_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = S_FIXUP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_FIXUP: begin
                    if (op_q[2]) begin
                        result_d = op_q[1] ? rem_fix : quo_fix;
                    end else begin
                        result_d = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
                    end
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
                S_DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            endcase
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            sign_a_q     <= sign_a_d;
            sign_b_q     <= sign_b_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            resp_valid_q <= resp_valid_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_result_o = result_q;
    assign resp_tag_o    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, randomized ops against a native
// arithmetic model, back-pressure, flush and mid-operation reset.
module tb_muldiv_unit;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       req_op_i;
    logic [XLEN-1:0]  req_a_i;
    logic [XLEN-1:0]  req_b_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [XLEN-1:0]  resp_result_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             busy_o;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        int               lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_a_i       (req_a_i),
        .req_b_i       (req_b_i),
        .req_tag_i     (req_tag_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_result_o (resp_result_o),
        .resp_tag_o    (resp_tag_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        if (op[2] && b == 0) return 1;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 3;
    endfunction

    // Present one request (caller is #1 after a rising edge); drops valid and scrambles operands after accept
    task automatic start_req(input logic [2:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        req_tag_i   = tag;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_a_i     = $urandom;
        req_b_i     = $urandom;
    endtask

    task automatic wait_valid(output int edges);
        edges = 1;
        while (!resp_valid_o && edges < 100) begin
            @(posedge clk_i); #1;
            edges++;
        end
        if (!resp_valid_o) check("resp_timeout", 64'(resp_valid_o), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input int hold);
        exp_t e;
        int   edges;
        logic [TAG_W-1:0] tag;
        tag = TAG_W'($urandom);
        check({name, "_ready_idle"}, 64'(req_ready_o), 64'd1);
        sb_q.push_back('{res: exp_res, tag: tag, lat: model_lat(op, a, b)});
        start_req(op, a, b, tag);
        wait_valid(edges);
        e = sb_q.pop_front();
        check({name, "_latency"}, 64'(edges), 64'(e.lat));
        check({name, "_result"}, 64'(resp_result_o), 64'(e.res));
        check({name, "_tag"}, 64'(resp_tag_o), 64'(e.tag));
        check({name, "_busy"}, 64'({busy_o, req_ready_o}), 64'b10);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            check({name, "_hold"}, {31'b0, resp_valid_o, req_ready_o, resp_tag_o, resp_result_o},
                  {31'b0, 1'b1, 1'b0, e.tag, e.res});
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        check({name, "_release"}, 64'({resp_valid_o, req_ready_o, busy_o}), 64'b010);
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        logic [2:0]      op;
        logic [XLEN-1:0] a, b;
        int              seen;

        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        req_valid_i  = 1'b0;
        req_op_i     = '0;
        req_a_i      = '0;
        req_b_i      = '0;
        req_tag_i    = '0;
        resp_ready_i = 1'b0;
        #12;
        check("reset_state", {busy_o, req_ready_o, resp_valid_o, resp_tag_o, resp_result_o},
              {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op("mulhu",   3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0);
        run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_op("divu",    3'd5, 32'd100,        32'd7,         32'd14,        0);
        run_op("remu",    3'd7, 32'd100,        32'd7,         32'd2,         0);
        run_op("divu_z",  3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF, 0);
        run_op("rem_z",   3'd6, 32'h1234,       32'd0,         32'h1234,      0);
        run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        run_op("backpr",  3'd1, 32'h1234_5678,  32'h9ABC_DEF0,
               model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 10);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ((i % 6) == 5) ? 32'd0 : $urandom;
            if ((i % 4) == 3) b = b >> $urandom_range(8, 28);
            run_op("rand", op, a, b, model(op, a, b), 0);
        end

        // Flush mid-CALC with a competing request: unit must go idle and accept nothing
        start_req(3'd0, 32'd11, 32'd13, 5'd9);
        wait_edges(10);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_op_i    = 3'd0;
        @(posedge clk_i); #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        check("flush_calc", 64'({resp_valid_o, req_ready_o, busy_o}), 64'b010);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (resp_valid_o || busy_o) seen++;
        end
        check("flush_no_resp", 64'(seen), 64'd0);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        // Flush in DONE beats resp_ready_i
        start_req(3'd5, 32'h55, 32'd0, 5'd3);
        check("flush_done_pre", 64'(resp_valid_o), 64'd1);
        flush_i      = 1'b1;
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;
        check("flush_done", 64'({resp_valid_o, req_ready_o, busy_o}), 64'b010);

        // Mid-op async reset returns outputs to reset values immediately
        start_req(3'd4, 32'd1000, 32'd3, 5'd17);
        wait_edges(5);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("async_reset", {busy_o, req_ready_o, resp_valid_o, resp_tag_o, resp_result_o},
              {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_op("div_after_rst", 3'd4, 32'd1000, 32'hFFFF_FFFD, model(3'd4, 32'd1000, 32'hFFFF_FFFD), 0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
